// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single main-memory block port between the
// I-cache and the D-cache. One block transfer is in flight at a time, and
// simultaneous requests are granted round-robin. The busywait outputs are
// decoded from the current state so that a requester sees exactly one
// low cycle, in RESP, for each transfer it is granted.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transfer in flight; arbitrate pending requests
// SERVE_I | memory read running on behalf of the I-cache
// SERVE_D | memory read or write-back running on behalf of the D-cache
// RESP_I  | one-cycle release of i_busywait; i_readdata is valid
// RESP_D  | one-cycle release of d_busywait; d_readdata is valid
module mem_port_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               m_read,
  output logic               m_write,
  output logic [ADDR_W-1:0]  m_address,
  output logic [BLOCK_W-1:0] m_writedata,
  input  logic [BLOCK_W-1:0] m_readdata,
  input  logic               m_busywait
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // last_grant: 0 = I-cache was granted last, 1 = D-cache was granted last
  logic last_grant;
  // seen_busy: memory has raised busywait at least once in this transfer,
  // so a low busywait now means the transfer is done rather than not started
  logic seen_busy;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic complete;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Busywait follows the request except during that requester's RESP cycle
  assign i_busywait = i_req & (state != RESP_I);
  assign d_busywait = d_req & (state != RESP_D);

  // Next-state decode, round-robin grant and transfer completion detect
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time gets the port
        if (d_req && (!i_req || !last_grant)) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end
      end
      SERVE_I: begin
        if (seen_busy && !m_busywait) begin
          complete   = 1'b1;
          state_next = RESP_I;
        end
      end
      SERVE_D: begin
        if (seen_busy && !m_busywait) begin
          complete   = 1'b1;
          state_next = RESP_D;
        end
      end
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Round-robin history and busy-seen flag; the flag restarts on every grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      seen_busy  <= 1'b0;
    end else if (grant_i) begin
      last_grant <= 1'b0;
      seen_busy  <= 1'b0;
    end else if (grant_d) begin
      last_grant <= 1'b1;
      seen_busy  <= 1'b0;
    end else if ((state == SERVE_I || state == SERVE_D) && m_busywait) begin
      seen_busy <= 1'b1;
    end
  end

  // Registered memory-side command: captured at grant, strobes dropped at completion.
  // A D-cache request with both read and write high is a write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
    end else if (grant_i) begin
      m_read    <= 1'b1;
      m_write   <= 1'b0;
      m_address <= i_address;
    end else if (grant_d) begin
      m_read      <= ~d_write;
      m_write     <= d_write;
      m_address   <= d_address;
      m_writedata <= d_writedata;
    end else if (complete) begin
      m_read  <= 1'b0;
      m_write <= 1'b0;
    end
  end

  // Returned block is captured on read completion and held until the next one,
  // even if the requester withdrew mid-transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_readdata <= '0;
      d_readdata <= '0;
    end else if (complete && m_read) begin
      if (state == SERVE_I) begin
        i_readdata <= m_readdata;
      end else begin
        d_readdata <= m_readdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and hand-sequenced checks of the
// two-cache memory port arbiter against a simple busy-for-N memory model.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 28;
  localparam int BLOCK_W = 128;

  logic               clk;
  logic               reset;
  logic               i_read;
  logic [ADDR_W-1:0]  i_address;
  logic [BLOCK_W-1:0] i_readdata;
  logic               i_busywait;
  logic               d_read;
  logic               d_write;
  logic [ADDR_W-1:0]  d_address;
  logic [BLOCK_W-1:0] d_writedata;
  logic [BLOCK_W-1:0] d_readdata;
  logic               d_busywait;
  logic               m_read;
  logic               m_write;
  logic [ADDR_W-1:0]  m_address;
  logic [BLOCK_W-1:0] m_writedata;
  logic [BLOCK_W-1:0] m_readdata;
  logic               m_busywait;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit                 wr;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] wdata;
  } mem_txn_t;

  typedef struct {
    bit ir;
    bit dr;
    bit dw;
    bit ibw;
    bit dbw;
  } rst_vec_t;

  typedef struct {
    bit                 is_d;
    bit                 rd_too;
    bit                 wr;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] wdata;
    logic [BLOCK_W-1:0] rdata;
    int                 lat;
  } txn_vec_t;

  mem_txn_t exp_q[$];
  mem_txn_t cur;
  bit       strobe_q = 1'b0;

  int                 mem_lat = 1;
  int                 mem_cnt;
  bit                 use_fixed = 1'b1;
  logic [BLOCK_W-1:0] mem_rdata = '0;
  logic [BLOCK_W-1:0] i_model;
  logic [BLOCK_W-1:0] d_model;

  rst_vec_t rst_tbl[8];
  txn_vec_t tbl[6];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_readdata  (i_readdata),
    .i_busywait  (i_busywait),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_writedata (d_writedata),
    .d_readdata  (d_readdata),
    .d_busywait  (d_busywait),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_address   (m_address),
    .m_writedata (m_writedata),
    .m_readdata  (m_readdata),
    .m_busywait  (m_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BLOCK_W-1:0] blk(input logic [ADDR_W-1:0] a);
    return {a[15:0], a, ~a, a ^ 28'hA5A5A5A, a + 28'd1};
  endfunction

  // Memory model: busywait high for the first mem_lat cycles of a strobe
  always @(posedge clk or posedge reset) begin
    if (reset) mem_cnt <= 0;
    else if (m_read || m_write) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end
  assign m_busywait = (m_read || m_write) && (mem_cnt < mem_lat);
  assign m_readdata = use_fixed ? mem_rdata : blk(m_address);

  task automatic check(input string name, input logic [BLOCK_W-1:0] act,
                       input logic [BLOCK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory-side monitor: pops the expected transaction when a strobe rises
  // and checks the command stays stable for the whole transfer
  always @(negedge clk) begin
    if (!reset) begin
      check("strobe_exclusive", BLOCK_W'(m_read & m_write), '0);
      if ((m_read || m_write) && !strobe_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got addr %h expected none", m_address);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (m_read || m_write) begin
        check("m_write_dir", BLOCK_W'(m_write), BLOCK_W'(cur.wr));
        check("m_read_dir", BLOCK_W'(m_read), BLOCK_W'(!cur.wr));
        check("m_address", BLOCK_W'(m_address), BLOCK_W'(cur.addr));
        if (cur.wr) check("m_writedata", m_writedata, cur.wdata);
      end
    end
    strobe_q = !reset && (m_read || m_write);
  end

  task automatic wait_resp(input bit is_d, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((is_d ? d_busywait : i_busywait) && cyc < budget);
    if (is_d ? d_busywait : i_busywait) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got busywait 1 after %0d cycles expected 0", cyc);
    end
  endtask

  task automatic push_txn(input bit wr, input logic [ADDR_W-1:0] addr,
                          input logic [BLOCK_W-1:0] wdata);
    mem_txn_t t;
    t.wr = wr;
    t.addr = addr;
    t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  task automatic run_txn(input txn_vec_t v);
    int cyc;
    mem_lat   = v.lat;
    use_fixed = 1'b1;
    mem_rdata = v.rdata;
    push_txn(v.wr, v.addr, v.wdata);
    if (v.is_d) begin
      d_address   = v.addr;
      d_writedata = v.wdata;
      d_write     = v.wr;
      d_read      = !v.wr || v.rd_too;
    end else begin
      i_address = v.addr;
      i_read    = 1'b1;
    end
    wait_resp(v.is_d, v.lat + 10, cyc);
    check_int("resp_latency", cyc, v.lat + 2);
    if (!v.wr) begin
      if (v.is_d) d_model = v.rdata;
      else i_model = v.rdata;
    end
    check("i_readdata", i_readdata, i_model);
    check("d_readdata", d_readdata, d_model);
    check("strobe_low_resp", BLOCK_W'(m_read | m_write), '0);
    check("other_busywait", BLOCK_W'(v.is_d ? i_busywait : d_busywait), '0);
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    check("strobe_low_idle", BLOCK_W'(m_read | m_write), '0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    i_model = '0;
    d_model = '0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int cyc;

    rst_tbl[0] = '{0, 0, 0, 0, 0};
    rst_tbl[1] = '{1, 0, 0, 1, 0};
    rst_tbl[2] = '{0, 1, 0, 0, 1};
    rst_tbl[3] = '{0, 0, 1, 0, 1};
    rst_tbl[4] = '{1, 1, 0, 1, 1};
    rst_tbl[5] = '{1, 0, 1, 1, 1};
    rst_tbl[6] = '{0, 1, 1, 0, 1};
    rst_tbl[7] = '{1, 1, 1, 1, 1};

    tbl[0] = '{0, 0, 0, 28'h0000010, '0, {4{32'hAAAAAAAA}}, 5};
    tbl[1] = '{1, 0, 1, 28'h00000FF, {8{16'h1234}}, '0, 3};
    tbl[2] = '{1, 0, 0, 28'h0ABCDEF, '0, {4{32'h55550F0F}}, 1};
    tbl[3] = '{0, 0, 0, 28'hFFFFFFF, '0, {4{32'h01234567}}, 2};
    tbl[4] = '{1, 1, 1, 28'h0000100, {4{32'hDEADBEEF}}, '0, 4};
    tbl[5] = '{1, 0, 0, 28'h00000FF, '0, {4{32'hCAFEF00D}}, 7};

    reset       = 1'b1;
    i_read      = 1'b0;
    d_read      = 1'b0;
    d_write     = 1'b0;
    i_address   = '0;
    d_address   = '0;
    d_writedata = '0;
    i_model     = '0;
    d_model     = '0;
    repeat (2) @(negedge clk);

    // Reset state: registers cleared, busywaits follow their equations
    for (int k = 0; k < 8; k++) begin
      i_read  = rst_tbl[k].ir;
      d_read  = rst_tbl[k].dr;
      d_write = rst_tbl[k].dw;
      #1;
      check("rst_i_busywait", BLOCK_W'(i_busywait), BLOCK_W'(rst_tbl[k].ibw));
      check("rst_d_busywait", BLOCK_W'(d_busywait), BLOCK_W'(rst_tbl[k].dbw));
      check("rst_m_strobes", BLOCK_W'({m_read, m_write}), '0);
      check("rst_m_address", BLOCK_W'(m_address), '0);
      check("rst_m_writedata", m_writedata, '0);
      check("rst_i_readdata", i_readdata, '0);
      check("rst_d_readdata", d_readdata, '0);
    end
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single transactions from the table
    for (int k = 0; k < 6; k++) run_txn(tbl[k]);

    // Tie after reset: I first; I re-requests and D is served before I again
    pulse_reset();
    use_fixed = 1'b0;
    mem_lat   = 3;
    i_address = 28'h0000100;
    d_address = 28'h0000200;
    push_txn(1'b0, 28'h0000100, '0);
    push_txn(1'b0, 28'h0000200, '0);
    push_txn(1'b0, 28'h0000100, '0);
    i_read = 1'b1;
    d_read = 1'b1;
    wait_resp(1'b0, 20, cyc);
    check_int("tie1_i_latency", cyc, 5);
    check("tie1_d_waits", BLOCK_W'(d_busywait), BLOCK_W'(1'b1));
    i_model = blk(28'h0000100);
    check("tie1_i_readdata", i_readdata, i_model);
    wait_resp(1'b1, 20, cyc);
    check_int("tie1_d_latency", cyc, 6);
    check("tie1_i_waits", BLOCK_W'(i_busywait), BLOCK_W'(1'b1));
    d_model = blk(28'h0000200);
    check("tie1_d_readdata", d_readdata, d_model);
    d_read = 1'b0;
    wait_resp(1'b0, 20, cyc);
    check_int("tie1_i_again_latency", cyc, 6);
    i_read = 1'b0;
    @(negedge clk);

    // Tie again, last grant was I: D wins this time
    push_txn(1'b0, 28'h0000200, '0);
    push_txn(1'b0, 28'h0000100, '0);
    i_read = 1'b1;
    d_read = 1'b1;
    wait_resp(1'b1, 20, cyc);
    check_int("tie2_d_latency", cyc, 5);
    check("tie2_i_waits", BLOCK_W'(i_busywait), BLOCK_W'(1'b1));
    d_read = 1'b0;
    wait_resp(1'b0, 20, cyc);
    check_int("tie2_i_latency", cyc, 6);
    i_read = 1'b0;
    @(negedge clk);

    // Back-to-back D write-back then refill of the same block
    mem_lat     = 2;
    d_address   = 28'h0000300;
    d_writedata = {4{32'h0F1E2D3C}};
    push_txn(1'b1, 28'h0000300, {4{32'h0F1E2D3C}});
    d_write = 1'b1;
    wait_resp(1'b1, 20, cyc);
    check_int("b2b_wr_latency", cyc, 4);
    check("b2b_gap_resp", BLOCK_W'(m_read | m_write), '0);
    check("b2b_wr_readdata", d_readdata, d_model);
    push_txn(1'b0, 28'h0000300, '0);
    d_write = 1'b0;
    d_read  = 1'b1;
    @(negedge clk);
    check("b2b_gap_idle", BLOCK_W'(m_read | m_write), '0);
    wait_resp(1'b1, 20, cyc);
    check_int("b2b_rd_latency", cyc, 4);
    d_model = blk(28'h0000300);
    check("b2b_rd_readdata", d_readdata, d_model);
    d_read = 1'b0;
    @(negedge clk);

    // Reset in the third SERVE_D cycle, then restart with d_write still high
    mem_lat     = 6;
    d_address   = 28'h0000400;
    d_writedata = {4{32'h13579BDF}};
    push_txn(1'b1, 28'h0000400, {4{32'h13579BDF}});
    d_write = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_m_write_before", BLOCK_W'(m_write), BLOCK_W'(1'b1));
    reset = 1'b1;
    #1;
    check("mid_m_write_reset", BLOCK_W'(m_write), '0);
    check("mid_m_read_reset", BLOCK_W'(m_read), '0);
    check("mid_d_busywait", BLOCK_W'(d_busywait), BLOCK_W'(1'b1));
    @(negedge clk);
    reset   = 1'b0;
    i_model = '0;
    d_model = '0;
    push_txn(1'b1, 28'h0000400, {4{32'h13579BDF}});
    wait_resp(1'b1, 20, cyc);
    check_int("mid_restart_latency", cyc, 8);
    d_write = 1'b0;
    @(negedge clk);

    // i_read withdrawn mid-SERVE_I: transfer completes, pending D goes next
    mem_lat   = 4;
    i_address = 28'h0000500;
    d_address = 28'h0000600;
    push_txn(1'b0, 28'h0000500, '0);
    push_txn(1'b0, 28'h0000600, '0);
    i_read = 1'b1;
    repeat (2) @(negedge clk);
    d_read = 1'b1;
    @(negedge clk);
    i_read = 1'b0;
    wait_resp(1'b1, 30, cyc);
    check_int("wd_d_latency", cyc, 10);
    i_model = blk(28'h0000500);
    d_model = blk(28'h0000600);
    check("wd_i_readdata", i_readdata, i_model);
    check("wd_d_readdata", d_readdata, d_model);
    d_read = 1'b0;
    repeat (2) @(negedge clk);

    check_int("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single main-memory block port between the instruction cache and the data cache. It sits between both cache controllers and main memory. It serializes block reads and write-backs one transaction at a time, and generates each cache's busywait, which ultimately stalls the IF/ID stage register and the rest of the pipeline. Simultaneous requests are resolved round-robin, so neither cache can starve the other.

## Interface
- ADDR_W, 28, block address width (word address bits above the 16-byte block offset)
- BLOCK_W, 128, block data width
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high
- i_read  input  1  I-cache block read request; held until i_busywait low
- i_address  input  ADDR_W  I-cache block address
- i_readdata  output  BLOCK_W  block returned to I-cache
- i_busywait  output  1  I-cache stall
- d_read  input  1  D-cache block read request
- d_write  input  1  D-cache block write-back request
- d_address  input  ADDR_W  D-cache block address
- d_writedata  input  BLOCK_W  write-back block
- d_readdata  output  BLOCK_W  block returned to D-cache
- d_busywait  output  1  D-cache stall
- m_read  output  1  memory read strobe
- m_write  output  1  memory write strobe
- m_address  output  ADDR_W  memory block address
- m_writedata  output  BLOCK_W  memory write data
- m_readdata  input  BLOCK_W  memory read data, valid when m_busywait falls
- m_busywait  input  1  memory busy

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- Register last_grant is 1 bit: 0 = I, 1 = D.
- Register seen_busy is 1 bit.
- IDLE:
  - Only one request pending: go to that requester's SERVE state.
  - Both pending: grant the requester not equal to last_grant.
  - On grant: latch address, write data (D only), and direction into m_* registers; set last_grant; clear seen_busy.
  - Direction: d_read and d_write both high means write.
- SERVE_x:
  - m_read or m_write asserts from the latched direction.
  - seen_busy sets when m_busywait is 1.
  - Completion is the first cycle with seen_busy=1 (or m_busywait=1 the cycle before) and m_busywait=0.
  - On completion: latch m_readdata into x_readdata (reads only); deassert m_read/m_write; go to RESP_x.
- RESP_x: one cycle. x_busywait=0. Next state is IDLE.
- x_readdata holds its value until the next read completion for that requester.
- Busywait logic (combinational):
  - i_busywait = i_read AND NOT (state==RESP_I).
  - d_busywait = (d_read OR d_write) AND NOT (state==RESP_D).
- A requester that keeps its request asserted after its RESP cycle is treated as a new request.
- Request withdrawn while in SERVE_x: the memory transaction still completes (no abort). RESP_x still occurs, and the response is discarded.
- Memory-side outputs are registered; requester inputs are never forwarded combinationally to m_*.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (I wins the first tie), seen_busy = 0.
  - m_read = m_write = 0, m_address = 0, m_writedata = 0.
  - i_readdata = d_readdata = 0.
  - Busywaits follow their equations, i.e. high for any asserted request.
- Reset mid-transfer: m_read/m_write drop immediately (async). The in-flight transaction is abandoned.
- Latency, with a request seen in IDLE at edge 0 and memory busy for N cycles:
  - m_read/m_write high from edge 1.
  - Completion is the cycle where m_busywait is low, nominally edge 1+N.
  - RESP occupies cycle 2+N; requester busywait is low for exactly that cycle.
- Minimum gap between consecutive memory transactions is 2 idle cycles on m_read/m_write (the RESP and IDLE cycles).
- The losing requester keeps busywait high throughout and is granted on the IDLE following the winner's RESP.

## Test plan
- Single I read, memory latency 5, i_address=0x0000010, m_readdata=0xAAAA…AAAA:
  - m_read=1 with m_address=0x0000010 from edge 1.
  - i_busywait=1 until RESP_I, then 0 for one cycle with i_readdata=0xAAAA…AAAA.
  - d_busywait stays 0.
- I read and D read raised in the same cycle after reset:
  - I is served first (last_grant reset=1).
  - D is granted on the IDLE after RESP_I.
  - Repeat the tie: D is served first.
- D write-back, d_address=0x00000FF, d_writedata=0x1234…:
  - m_write=1, m_read=0, m_writedata=0x1234… held until completion.
  - d_readdata unchanged.
- Back-to-back D write then D read (write-back then refill):
  - Two distinct transactions, each with its own RESP_D cycle.
  - m_read and m_write are never high together.
- Reset asserted at the third SERVE_D cycle:
  - m_write=0 in the same cycle; state IDLE.
  - After reset release with d_write still high, the transaction restarts from edge 1.
- i_read dropped mid-SERVE_I:
  - Memory transaction completes; RESP_I occurs with i_busywait=0.
  - A pending d_read is granted next.
